// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: register ids, register count, data word
// type and a population-count helper used by the issue scoreboard.
package riscv_pkg;

    localparam int REG_COUNT = 32;
    localparam int XLEN      = 32;

    typedef logic [4:0]      reg_id_t;
    typedef logic [XLEN-1:0] xword_t;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/riscv_wb_arbiter.sv
// Writeback arbiter: fixed priority (load over ALU), one acceptance per cycle,
// registered onto the register-file write port one cycle after acceptance.
// Ports: clk, resetn, flush, alu_wb_* / mem_wb_* handshakes, rf_write/rf_rw/rf_d.
module riscv_wb_arbiter
    import riscv_pkg::*;
(
    input  logic    clk,
    input  logic    resetn,
    input  logic    flush,
    input  logic    alu_wb_valid,
    input  reg_id_t alu_wb_rd,
    input  xword_t  alu_wb_data,
    output logic    alu_wb_ready,
    input  logic    mem_wb_valid,
    input  reg_id_t mem_wb_rd,
    input  xword_t  mem_wb_data,
    output logic    mem_wb_ready,
    output logic    rf_write,
    output reg_id_t rf_rw,
    output xword_t  rf_d
);

    logic    acc;
    reg_id_t acc_rd;
    xword_t  acc_d;

    assign mem_wb_ready = 1'b1;
    assign alu_wb_ready = ~mem_wb_valid;

    always_comb begin
        acc    = mem_wb_valid | alu_wb_valid;
        acc_rd = mem_wb_valid ? mem_wb_rd : alu_wb_rd;
        acc_d  = mem_wb_valid ? mem_wb_data : alu_wb_data;
    end

    // Writebacks accepted under flush, or targeting x0, complete the
    // handshake but never reach the register file.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rf_write <= 1'b0;
            rf_rw    <= '0;
            rf_d     <= '0;
        end else begin
            rf_write <= acc & ~flush & (acc_rd != '0);
            if (acc) begin
                rf_rw <= acc_rd;
                rf_d  <= acc_d;
            end
        end
    end

endmodule

// File: rtl/riscv_issue_scoreboard.sv
// Issue scoreboard: tracks registers with outstanding writes, stalls RAW/WAW
// hazards, and commits arbitrated writebacks to the register file.
// Ports: clk, resetn, id_* decode/issue, alu_wb_*/mem_wb_*, rf_*, flush, pending*.
module riscv_issue_scoreboard
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        id_valid,
    input  reg_id_t     id_rs1,
    input  reg_id_t     id_rs2,
    input  reg_id_t     id_rd,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        id_write_rd,
    output logic        id_issue,
    output logic        id_stall,
    input  logic        alu_wb_valid,
    input  reg_id_t     alu_wb_rd,
    input  xword_t      alu_wb_data,
    output logic        alu_wb_ready,
    input  logic        mem_wb_valid,
    input  reg_id_t     mem_wb_rd,
    input  xword_t      mem_wb_data,
    output logic        mem_wb_ready,
    output logic        rf_write,
    output reg_id_t     rf_rw,
    output xword_t      rf_d,
    input  logic        flush,
    output logic [31:0] pending,
    output logic [5:0]  pending_count
);

    logic        hazard;
    logic [31:0] pending_nxt;

    assign hazard = id_valid & ((id_use_rs1 & pending[id_rs1]) |
                                (id_use_rs2 & pending[id_rs2]) |
                                (id_write_rd & pending[id_rd]));

    assign id_issue      = id_valid & ~hazard & ~flush;
    assign id_stall      = id_valid & ~id_issue;
    assign pending_count = popcount32(pending);

    // A bit stays set through its rf_write cycle, so a WAW issue to the same
    // register is stalled and set/clear of one bit never coincide.
    always_comb begin
        pending_nxt = pending;
        if (rf_write) begin
            pending_nxt[rf_rw] = 1'b0;
        end
        if (id_issue && id_write_rd && id_rd != '0) begin
            pending_nxt[id_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending <= '0;
        end else if (flush) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    riscv_wb_arbiter u_wb_arbiter (
        .clk          (clk),
        .resetn       (resetn),
        .flush        (flush),
        .alu_wb_valid (alu_wb_valid),
        .alu_wb_rd    (alu_wb_rd),
        .alu_wb_data  (alu_wb_data),
        .alu_wb_ready (alu_wb_ready),
        .mem_wb_valid (mem_wb_valid),
        .mem_wb_rd    (mem_wb_rd),
        .mem_wb_data  (mem_wb_data),
        .mem_wb_ready (mem_wb_ready),
        .rf_write     (rf_write),
        .rf_rw        (rf_rw),
        .rf_d         (rf_d)
    );

endmodule

// File: tb/tb_riscv_issue_scoreboard.sv
// Testbench for riscv_issue_scoreboard: directed vectors, expected register
// file writes queued by stimulus and checked by an independent monitor.
module tb_riscv_issue_scoreboard;

    logic        clk;
    logic        resetn;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2, id_write_rd;
    logic        id_issue, id_stall;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_rd;
    logic [31:0] alu_wb_data;
    logic        alu_wb_ready;
    logic        mem_wb_valid;
    logic [4:0]  mem_wb_rd;
    logic [31:0] mem_wb_data;
    logic        mem_wb_ready;
    logic        rf_write;
    logic [4:0]  rf_rw;
    logic [31:0] rf_d;
    logic        flush;
    logic [31:0] pending;
    logic [5:0]  pending_count;

    riscv_issue_scoreboard dut (
        .clk           (clk),
        .resetn        (resetn),
        .id_valid      (id_valid),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .id_write_rd   (id_write_rd),
        .id_issue      (id_issue),
        .id_stall      (id_stall),
        .alu_wb_valid  (alu_wb_valid),
        .alu_wb_rd     (alu_wb_rd),
        .alu_wb_data   (alu_wb_data),
        .alu_wb_ready  (alu_wb_ready),
        .mem_wb_valid  (mem_wb_valid),
        .mem_wb_rd     (mem_wb_rd),
        .mem_wb_data   (mem_wb_data),
        .mem_wb_ready  (mem_wb_ready),
        .rf_write      (rf_write),
        .rf_rw         (rf_rw),
        .rf_d          (rf_d),
        .flush         (flush),
        .pending       (pending),
        .pending_count (pending_count)
    );

    typedef struct {
        int          cyc;
        logic [4:0]  rw;
        logic [31:0] d;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every rf_write must match the oldest queued expectation, in
    // the expected cycle; an expectation left behind its cycle is a miss.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0 && q[0].cyc < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missed_wb: cyc=%0d no rf_write, required rw=%0d d=%h at cyc %0d",
                     cyc, q[0].rw, q[0].d, q[0].cyc);
            void'(q.pop_front());
        end
        if (rf_write) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_wb: cyc=%0d rw=%0d d=%h, required no write",
                         cyc, rf_rw, rf_d);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || e.rw != rf_rw || e.d != rf_d) begin
                    n_bad++;
                    $display("FAIL rf_port: cyc=%0d rw=%0d d=%h, required cyc=%0d rw=%0d d=%h",
                             cyc, rf_rw, rf_d, e.cyc, e.rw, e.d);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic expect_wb(input logic [4:0] rw, input logic [31:0] d);
        exp_t e;
        e.cyc = cyc + 1;
        e.rw  = rw;
        e.d   = d;
        q.push_back(e);
    endtask

    task automatic idle();
        id_valid     = 1'b0;
        id_rs1       = '0;
        id_rs2       = '0;
        id_rd        = '0;
        id_use_rs1   = 1'b0;
        id_use_rs2   = 1'b0;
        id_write_rd  = 1'b0;
        alu_wb_valid = 1'b0;
        alu_wb_rd    = '0;
        alu_wb_data  = '0;
        mem_wb_valid = 1'b0;
        mem_wb_rd    = '0;
        mem_wb_data  = '0;
        flush        = 1'b0;
    endtask

    // Advance one cycle; inputs return to idle 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic issue_wr(input logic [4:0] rd);
        id_valid    = 1'b1;
        id_rd       = rd;
        id_write_rd = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        idle();
        // Reset: combinational path still live, registered state cleared.
        @(posedge clk);
        #1;
        id_valid = 1'b1;
        id_rd    = 5'd8;
        id_write_rd = 1'b1;
        #1;
        chk("rst_issue", {31'd0, id_issue}, 32'd1);
        chk("rst_pending", pending, 32'd0);
        chk("rst_count", {26'd0, pending_count}, 32'd0);
        chk("rst_rf_write", {31'd0, rf_write}, 32'd0);
        tick();
        chk("rst_pending_hold", pending, 32'd0);
        resetn = 1'b1;
        tick();

        // RAW on x5
        issue_wr(5'd5);
        #1 chk("raw_first_issue", {31'd0, id_issue}, 32'd1);
        tick();
        issue_wr(5'd6);
        id_rs1 = 5'd5;
        id_use_rs1 = 1'b1;
        #1 chk("raw_pending", pending, 32'h0000_0020);
        chk("raw_stall", {31'd0, id_stall}, 32'd1);
        chk("raw_no_issue", {31'd0, id_issue}, 32'd0);
        tick();
        issue_wr(5'd6);
        id_rs1 = 5'd5;
        id_use_rs1 = 1'b1;
        mem_wb_valid = 1'b1;
        mem_wb_rd = 5'd5;
        mem_wb_data = 32'h1234_5678;
        expect_wb(5'd5, 32'h1234_5678);
        #1 chk("raw_stall_accept", {31'd0, id_stall}, 32'd1);
        chk("raw_mem_ready", {31'd0, mem_wb_ready}, 32'd1);
        tick();
        issue_wr(5'd6);
        id_rs1 = 5'd5;
        id_use_rs1 = 1'b1;
        #1 chk("raw_stall_rfw", {31'd0, id_stall}, 32'd1);
        chk("raw_pending_rfw", pending, 32'h0000_0020);
        tick();
        issue_wr(5'd6);
        id_rs1 = 5'd5;
        id_use_rs1 = 1'b1;
        #1 chk("raw_issue_after", {31'd0, id_issue}, 32'd1);
        chk("raw_pending_clr", pending, 32'd0);
        tick();
        #1 chk("raw_pending_x6", pending, 32'h0000_0040);
        chk("raw_count", {26'd0, pending_count}, 32'd1);

        // Collision: load wins, ALU retries next cycle
        alu_wb_valid = 1'b1;
        alu_wb_rd = 5'd3;
        alu_wb_data = 32'h0000_AAAA;
        mem_wb_valid = 1'b1;
        mem_wb_rd = 5'd4;
        mem_wb_data = 32'h0000_5555;
        expect_wb(5'd4, 32'h0000_5555);
        #1 chk("col_alu_ready", {31'd0, alu_wb_ready}, 32'd0);
        tick();
        alu_wb_valid = 1'b1;
        alu_wb_rd = 5'd3;
        alu_wb_data = 32'h0000_AAAA;
        expect_wb(5'd3, 32'h0000_AAAA);
        #1 chk("col_alu_ready2", {31'd0, alu_wb_ready}, 32'd1);
        tick();
        alu_wb_valid = 1'b1;
        alu_wb_rd = 5'd6;
        alu_wb_data = 32'h0000_0066;
        expect_wb(5'd6, 32'h0000_0066);
        tick();
        tick();
        #1 chk("col_pending_clr", pending, 32'd0);

        // x0 is never tracked nor written
        issue_wr(5'd0);
        #1 chk("x0_issue", {31'd0, id_issue}, 32'd1);
        tick();
        alu_wb_valid = 1'b1;
        alu_wb_rd = 5'd0;
        alu_wb_data = 32'h0000_DEAD;
        #1 chk("x0_pending", pending, 32'd0);
        chk("x0_alu_ready", {31'd0, alu_wb_ready}, 32'd1);
        tick();
        #1 chk("x0_rf_write", {31'd0, rf_write}, 32'd0);

        // WAW on x10
        issue_wr(5'd10);
        tick();
        issue_wr(5'd10);
        #1 chk("waw_stall", {31'd0, id_stall}, 32'd1);
        tick();
        issue_wr(5'd10);
        mem_wb_valid = 1'b1;
        mem_wb_rd = 5'd10;
        mem_wb_data = 32'h0000_000A;
        expect_wb(5'd10, 32'h0000_000A);
        #1 chk("waw_stall_accept", {31'd0, id_stall}, 32'd1);
        tick();
        issue_wr(5'd10);
        #1 chk("waw_stall_rfw", {31'd0, id_stall}, 32'd1);
        tick();
        issue_wr(5'd10);
        #1 chk("waw_issue", {31'd0, id_issue}, 32'd1);
        tick();
        mem_wb_valid = 1'b1;
        mem_wb_rd = 5'd10;
        mem_wb_data = 32'h0000_000B;
        expect_wb(5'd10, 32'h0000_000B);
        #1 chk("waw_pending_reset", pending, 32'h0000_0400);
        tick();
        tick();
        #1 chk("waw_pending_clr", pending, 32'd0);

        // Flush with pending {7,9}; a committed write in the flush cycle completes
        issue_wr(5'd7);
        tick();
        issue_wr(5'd9);
        tick();
        alu_wb_valid = 1'b1;
        alu_wb_rd = 5'd12;
        alu_wb_data = 32'h0000_C0DE;
        expect_wb(5'd12, 32'h0000_C0DE);
        #1 chk("fl_pending", pending, 32'h0000_0280);
        chk("fl_count", {26'd0, pending_count}, 32'd2);
        tick();
        flush = 1'b1;
        mem_wb_valid = 1'b1;
        mem_wb_rd = 5'd7;
        mem_wb_data = 32'h0000_7777;
        issue_wr(5'd11);
        #1 chk("fl_no_issue", {31'd0, id_issue}, 32'd0);
        chk("fl_stall", {31'd0, id_stall}, 32'd1);
        chk("fl_mem_ready", {31'd0, mem_wb_ready}, 32'd1);
        chk("fl_rfw_commit", {31'd0, rf_write}, 32'd1);
        tick();
        #1 chk("fl_pending_clr", pending, 32'd0);
        chk("fl_no_rfw", {31'd0, rf_write}, 32'd0);

        // Reset mid-writeback
        issue_wr(5'd2);
        tick();
        alu_wb_valid = 1'b1;
        alu_wb_rd = 5'd2;
        alu_wb_data = 32'h0000_0222;
        #1 chk("rm_pending_pre", pending, 32'h0000_0004);
        resetn = 1'b0;
        #1 chk("rm_rf_write", {31'd0, rf_write}, 32'd0);
        chk("rm_pending", pending, 32'd0);
        chk("rm_count", {26'd0, pending_count}, 32'd0);
        tick();
        resetn = 1'b1;
        tick();
        tick();
        #1 chk("rm_rf_write_after", {31'd0, rf_write}, 32'd0);
        tick();
        tick();
        chk("queue_empty", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/riscv_issue_scoreboard.md
RISCV_ISSUE_SCOREBOARD -- requirements
Module: riscv_issue_scoreboard

Interface
REQ-001 SHALL have: clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have: resetn  input  1  asynchronous, active-low reset.
REQ-003 SHALL have: id_valid  input  1  decoded instruction present.
REQ-004 SHALL have: id_rs1, id_rs2, id_rd  input  5 each  register ids (reg_id_t).
REQ-005 SHALL have: id_use_rs1, id_use_rs2, id_write_rd  input  1 each  operand/destination usage flags.
REQ-006 SHALL have: id_issue  output  1  instruction issued this cycle.
REQ-007 SHALL have: id_stall  output  1  id_valid held back by a hazard or flush.
REQ-008 SHALL have: alu_wb_valid  input  1, alu_wb_rd  input  5, alu_wb_data  input  32, alu_wb_ready  output  1  ALU writeback handshake.
REQ-009 SHALL have: mem_wb_valid  input  1, mem_wb_rd  input  5, mem_wb_data  input  32, mem_wb_ready  output  1  load writeback handshake.
REQ-010 SHALL have: rf_write  output  1, rf_rw  output  5, rf_d  output  32  register-file write port (drives write/rw/d).
REQ-011 SHALL have: flush  input  1  squash all issued, uncommitted instructions.
REQ-012 SHALL have: pending  output  32  scoreboard vector; pending_count  output  6  popcount of pending.

Function
REQ-013 SHALL keep pending[31:0]; bit 0 is constant 0; x0 is never pending.
REQ-014 SHALL compute hazard = id_valid & ((use_rs1 & pending[rs1]) | (use_rs2 & pending[rs2]) | (write_rd & pending[rd])); RAW and WAW both stall.
REQ-015 SHALL assert id_issue = id_valid & ~hazard & ~flush, combinationally; id_stall = id_valid & ~id_issue.
REQ-016 SHALL set pending[id_rd] on the edge ending an id_issue cycle when id_write_rd=1 and id_rd!=0.
REQ-017 SHALL arbitrate writebacks with fixed priority: mem_wb_ready=1 always; alu_wb_ready = ~mem_wb_valid.
REQ-018 SHALL treat a writeback as accepted when valid & ready; one acceptance maximum per cycle.
REQ-019 SHALL register the accepted writeback: rf_write/rf_rw/rf_d assert exactly 1 cycle after acceptance, for 1 cycle.
REQ-020 SHALL drive rf_write=0 for accepted writebacks with rd=0 (handshake still completes).
REQ-021 SHALL clear pending[rf_rw] on the edge ending a cycle with rf_write=1 (commit edge), so a dependent issues the cycle after the RF write.
REQ-022 SHALL hold pending[rd]=1 during the rf_write cycle, so set and clear of the same bit in one cycle cannot occur (WAW stall).
REQ-023 SHALL, on flush: block issue that cycle; still accept writebacks that cycle but drop them (rf_write=0 next cycle); clear all pending bits at the next edge.
REQ-024 SHALL complete an rf_write already asserted in the flush cycle (committed state).
REQ-025 SHALL produce pending_count combinationally as popcount(pending), range 0..31.

Reset
REQ-026 SHALL, while resetn=0, asynchronously force pending=0, rf_write=0, rf_rw=0, rf_d=0.
REQ-027 SHALL, during reset, still drive combinational outputs from inputs with pending=0 (id_issue=id_valid & ~flush).
REQ-028 SHALL discard any in-progress writeback when reset asserts mid-operation; no rf_write after release without new acceptance.

Structure
REQ-029 SHALL take reg_id_t and REG_COUNT=32 from shared package riscv_pkg (moved out of the register-file include).
REQ-030 SHALL place the writeback arbiter plus output register in sub-module riscv_wb_arbiter; scoreboard and issue logic stay in the top.

Verification
REQ-031 SHALL cover RAW: issue rd=5; next id rs1=5 -> id_stall=1 until mem_wb rd=5 accepted, rf_write cycle seen, then id_issue=1 the following cycle.
REQ-032 SHALL cover collision: alu_wb(rd=3,0xAAAA) and mem_wb(rd=4,0x5555) same cycle -> alu_wb_ready=0, rf_rw=4/rf_d=0x5555 next cycle, ALU write rd=3 one cycle later.
REQ-033 SHALL cover x0: issue rd=0, writeback rd=0 -> pending stays 0, rf_write stays 0, handshake completes.
REQ-034 SHALL cover flush: pending={7,9}, flush with mem_wb rd=7 -> pending=0 next edge, no rf_write for rd=7, id_issue=0 in flush cycle.
REQ-035 SHALL cover WAW: pending[10]=1, id rd=10 write_rd=1 no reads -> stall until commit of rd=10.
REQ-036 SHALL cover reset mid-writeback: accept alu_wb rd=2, assert resetn=0 same cycle -> rf_write=0, pending=0, pending_count=0.
